trap_sequencer: RTL and testbench

- Machine-mode trap/return controller that sequences the CSR file's single write port on exception, external interrupt and MRET.
- Sits beside the WB stage. Accepts one trap or MRET event and stalls the pipeline while it drives the mepc, mtval, mcause and mstatus updates in order.
- Finishes by issuing a one-cycle PC redirect plus flush.

---
 rtl/trap_pkg.sv | 31 +++
 rtl/trap_cause_enc.sv | 69 ++++++
 rtl/trap_sequencer.sv | 164 ++++++++++++++++
 tb/tb_trap_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// States, CSR addresses, cause codes and mstatus bit positions.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_STATUS,
    R_STATUS,
    REDIR
  } state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;

  localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
  localparam logic [4:0] CAUSE_ECALL   = 5'd11;
  localparam logic [4:0] CAUSE_LFAULT  = 5'd5;
  localparam logic [4:0] CAUSE_SFAULT  = 5'd7;
  localparam logic [4:0] CAUSE_MEI     = 5'd11;

  localparam int MIE    = 3;
  localparam int MPIE   = 7;
  localparam int MPP_HI = 12;
  localparam int MPP_LO = 11;

endpackage

// File: rtl/trap_cause_enc.sv
// Priority encoder from raw event flags to the event to accept.
// Order: irq > illegal > ecall > lfault > sfault > mret.
module trap_cause_enc
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            ex_illegal,
  input  logic            ex_ecall,
  input  logic            ex_lfault,
  input  logic            ex_sfault,
  input  logic            irq_ext,
  input  logic            mret,
  input  logic            wb_valid,
  input  logic            mie,
  output logic            take,
  output logic            is_mret,
  output logic [XLEN-1:0] cause,
  output logic            tval_sel
);

  logic irq_hit;
  logic ill_hit;
  logic ecl_hit;
  logic lf_hit;
  logic sf_hit;
  logic mrt_hit;

  assign irq_hit = irq_ext & mie;
  assign ill_hit = wb_valid & ex_illegal & ~irq_hit;
  assign ecl_hit = wb_valid & ex_ecall & ~irq_hit & ~ex_illegal;
  assign lf_hit  = wb_valid & ex_lfault & ~irq_hit
                 & ~ex_illegal & ~ex_ecall;
  assign sf_hit  = wb_valid & ex_sfault & ~irq_hit
                 & ~ex_illegal & ~ex_ecall & ~ex_lfault;
  assign mrt_hit = wb_valid & mret & ~irq_hit
                 & ~ex_illegal & ~ex_ecall
                 & ~ex_lfault & ~ex_sfault;

  // One-hot hits select cause code and mtval source.
  always_comb begin
    take     = 1'b1;
    is_mret  = 1'b0;
    cause    = '0;
    tval_sel = 1'b0;
    unique case (1'b1)
      irq_hit: begin
        cause[XLEN-1] = 1'b1;
        cause[4:0]    = CAUSE_MEI;
      end
      ill_hit: begin
        cause[4:0] = CAUSE_ILLEGAL;
        tval_sel   = 1'b1;
      end
      ecl_hit: cause[4:0] = CAUSE_ECALL;
      lf_hit: begin
        cause[4:0] = CAUSE_LFAULT;
        tval_sel   = 1'b1;
      end
      sf_hit: begin
        cause[4:0] = CAUSE_SFAULT;
        tval_sel   = 1'b1;
      end
      mrt_hit: is_mret = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/MRET sequencer driving the CSR write port.
// Stalls the pipeline, writes mepc/mcause/mstatus, then redirects.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_illegal,
  input  logic            ex_ecall,
  input  logic            ex_lfault,
  input  logic            ex_sfault,
  input  logic            irq_ext,
  input  logic            mret,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [XLEN-1:0] wb_tval,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            csr_w,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [1:0]      csr_wsc_mode,
  output logic [XLEN-1:0] mtval_data,
  output logic            mtval_data_in,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic            mret_q, mret_d;

  logic            take;
  logic            is_mret;
  logic [XLEN-1:0] enc_cause;
  logic            tval_sel;
  logic [XLEN-1:0] st_trap;
  logic [XLEN-1:0] st_mret;
  logic [XLEN-1:0] vec_off;
  logic            vec_en;

  trap_cause_enc #(.XLEN(XLEN)) u_enc (
    .ex_illegal (ex_illegal),
    .ex_ecall   (ex_ecall),
    .ex_lfault  (ex_lfault),
    .ex_sfault  (ex_sfault),
    .irq_ext    (irq_ext),
    .mret       (mret),
    .wb_valid   (wb_valid),
    .mie        (mstatus[MIE]),
    .take       (take),
    .is_mret    (is_mret),
    .cause      (enc_cause),
    .tval_sel   (tval_sel)
  );

  assign csr_wsc_mode = 2'b01;
  assign vec_en  = VECTORED_EN && (mtvec[1:0] == 2'b01)
                 && cause_q[XLEN-1];
  assign vec_off = {cause_q[XLEN-3:0], 2'b00};

  // mstatus images for trap entry and MRET, built from live mstatus.
  always_comb begin
    st_trap                = mstatus;
    st_trap[MPIE]          = mstatus[MIE];
    st_trap[MIE]           = 1'b0;
    st_trap[MPP_HI:MPP_LO] = 2'b11;
    st_mret                = mstatus;
    st_mret[MIE]           = mstatus[MPIE];
    st_mret[MPIE]          = 1'b1;
    st_mret[MPP_HI:MPP_LO] = 2'b11;
  end

  // Next state, capture and per-state outputs.
  always_comb begin
    state_d        = state_q;
    epc_d          = epc_q;
    tval_d         = tval_q;
    cause_d        = cause_q;
    mret_d         = mret_q;
    csr_w          = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    mtval_data     = '0;
    mtval_data_in  = 1'b0;
    busy           = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state_q)
      IDLE: begin
        busy = take & ~rst;
        if (take) begin
          state_d = is_mret ? R_STATUS : T_EPC;
          epc_d   = wb_pc;
          tval_d  = tval_sel ? wb_tval : '0;
          cause_d = enc_cause;
          mret_d  = is_mret;
        end
      end
      T_EPC: begin
        csr_w         = 1'b1;
        csr_waddr     = CSR_MEPC;
        csr_wdata     = epc_q;
        mtval_data_in = 1'b1;
        mtval_data    = tval_q;
        state_d       = T_CAUSE;
      end
      T_CAUSE: begin
        csr_w     = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = cause_q;
        state_d   = T_STATUS;
      end
      T_STATUS: begin
        csr_w     = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = st_trap;
        state_d   = REDIR;
      end
      R_STATUS: begin
        csr_w     = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = st_mret;
        state_d   = REDIR;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        if (mret_q) begin
          redirect_pc = mepc;
        end else begin
          redirect_pc = {mtvec[XLEN-1:2], 2'b00}
                      + (vec_en ? vec_off : '0);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured event registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      epc_q   <= '0;
      tval_q  <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer.
// Vector table, hand sequences and a queue-based reference model.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_illegal, ex_ecall, ex_lfault, ex_sfault;
  logic        irq_ext, mret, wb_valid;
  logic [31:0] wb_pc, wb_tval, mstatus, mtvec, mepc;
  logic        csr_w;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [1:0]  csr_wsc_mode;
  logic [31:0] mtval_data;
  logic        mtval_data_in;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_sequencer #(.XLEN(32), .VECTORED_EN(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_illegal     (ex_illegal),
    .ex_ecall       (ex_ecall),
    .ex_lfault      (ex_lfault),
    .ex_sfault      (ex_sfault),
    .irq_ext        (irq_ext),
    .mret           (mret),
    .wb_valid       (wb_valid),
    .wb_pc          (wb_pc),
    .wb_tval        (wb_tval),
    .mstatus        (mstatus),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .csr_w          (csr_w),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .csr_wsc_mode   (csr_wsc_mode),
    .mtval_data     (mtval_data),
    .mtval_data_in  (mtval_data_in),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  typedef struct packed {
    logic        w;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [1:0]  mode;
    logic [31:0] mtd;
    logic        mti;
    logic        busy;
    logic        rv;
    logic [31:0] rpc;
  } out_t;

  // Scheduled per-cycle actions of an accepted event.
  typedef enum {A_EPC, A_CAUSE, A_TST, A_RST, A_RDT, A_RDR} act_e;
  typedef struct {
    act_e        a;
    logic [31:0] epc;
    logic [31:0] tval;
    logic [31:0] cause;
  } act_t;

  act_t q[$];
  out_t snap;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic is_trap();
    return (wb_valid & (ex_illegal | ex_ecall | ex_lfault | ex_sfault))
         | (irq_ext & mstatus[3]);
  endfunction

  function automatic logic [31:0] trap_cause();
    if (irq_ext && mstatus[3]) return 32'h8000_000B;
    if (ex_illegal) return 32'd2;
    if (ex_ecall) return 32'd11;
    if (ex_lfault) return 32'd5;
    return 32'd7;
  endfunction

  function automatic logic [31:0] st_trap(logic [31:0] m);
    return (m & ~32'h1888) | ({31'd0, m[3]} << 7) | 32'h1800;
  endfunction

  function automatic logic [31:0] st_mret(logic [31:0] m);
    return (m & ~32'h1888) | ({31'd0, m[7]} << 3) | 32'h1880;
  endfunction

  function automatic logic [31:0] trap_target(logic [31:0] c);
    logic [31:0] base;
    base = mtvec & ~32'h3;
    if (mtvec[1:0] == 2'b01 && c[31]) return base + 4 * (c & 32'h7FFF_FFFF);
    return base;
  endfunction

  function automatic out_t model_exp();
    out_t e;
    e = '0;
    e.mode = 2'b01;
    if (q.size() == 0) begin
      e.busy = !rst && (is_trap() || (wb_valid && mret));
    end else begin
      e.busy = 1'b1;
      case (q[0].a)
        A_EPC: begin
          e.w = 1; e.waddr = 12'h341; e.wdata = q[0].epc;
          e.mti = 1; e.mtd = q[0].tval;
        end
        A_CAUSE: begin e.w = 1; e.waddr = 12'h342; e.wdata = q[0].cause; end
        A_TST: begin e.w = 1; e.waddr = 12'h300; e.wdata = st_trap(mstatus); end
        A_RST: begin e.w = 1; e.waddr = 12'h300; e.wdata = st_mret(mstatus); end
        A_RDT: begin e.rv = 1; e.rpc = trap_target(q[0].cause); end
        default: begin e.rv = 1; e.rpc = mepc; end
      endcase
    end
    return e;
  endfunction

  task automatic model_adv();
    logic [31:0] c, t;
    if (rst) begin
      q.delete();
    end else if (q.size() != 0) begin
      void'(q.pop_front());
    end else if (is_trap()) begin
      c = trap_cause();
      t = (c == 32'h8000_000B || c == 32'd11) ? 32'd0 : wb_tval;
      q.push_back('{A_EPC, wb_pc, t, c});
      q.push_back('{A_CAUSE, wb_pc, t, c});
      q.push_back('{A_TST, wb_pc, t, c});
      q.push_back('{A_RDT, wb_pc, t, c});
    end else if (wb_valid && mret) begin
      q.push_back('{A_RST, 32'd0, 32'd0, 32'd0});
      q.push_back('{A_RDR, 32'd0, 32'd0, 32'd0});
    end
  endtask

  // Inputs are set just after negedge; outputs sampled 1 time unit later.
  task automatic tick();
    out_t e;
    #1;
    e = model_exp();
    snap = {csr_w, csr_waddr, csr_wdata, csr_wsc_mode, mtval_data,
            mtval_data_in, busy, redirect_valid, redirect_pc};
    chk("cycle", 128'(snap), 128'(e));
    model_adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_ev();
    ex_illegal = 0; ex_ecall = 0; ex_lfault = 0; ex_sfault = 0;
    irq_ext = 0; mret = 0;
  endtask

  typedef struct {
    string       nm;
    logic [5:0]  ev;
    logic        wbv;
    logic [31:0] ms, tv, pc, tval, ep;
    logic        x_take;
    logic [31:0] x_cause, x_st, x_mtval, x_rpc;
    int          x_lat;
  } vec_t;

  vec_t vecs[$];

  // ev bits: {irq, illegal, ecall, lfault, sfault, mret}
  task automatic run_vec(vec_t v);
    logic [31:0] cs, st, mt, rp;
    int lat;
    cs = 0; st = 0; mt = 0; rp = 0; lat = 0;
    {irq_ext, ex_illegal, ex_ecall, ex_lfault, ex_sfault, mret} = v.ev;
    wb_valid = v.wbv; mstatus = v.ms; mtvec = v.tv;
    wb_pc = v.pc; wb_tval = v.tval; mepc = v.ep;
    tick();
    chk({v.nm, "_busy"}, 128'(snap.busy), 128'(v.x_take));
    clr_ev();
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (snap.w && snap.waddr == 12'h342) cs = snap.wdata;
      if (snap.w && snap.waddr == 12'h300) st = snap.wdata;
      if (snap.mti) mt = snap.mtd;
      if (snap.rv) begin
        rp = snap.rpc;
        lat = k;
        break;
      end
    end
    chk({v.nm, "_cause"}, 128'(cs), 128'(v.x_cause));
    chk({v.nm, "_mstatus"}, 128'(st), 128'(v.x_st));
    chk({v.nm, "_mtval"}, 128'(mt), 128'(v.x_mtval));
    chk({v.nm, "_rpc"}, 128'(rp), 128'(v.x_rpc));
    chk({v.nm, "_lat"}, 128'(lat), 128'(v.x_lat));
  endtask

  initial begin
    logic [31:0] seen;
    vec_t v;
    out_t r;
    rst = 1; clr_ev(); wb_valid = 0;
    wb_pc = 0; wb_tval = 0; mstatus = 0; mtvec = 0; mepc = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);

    tick();
    r = '0; r.mode = 2'b01;
    chk("reset_outputs", 128'(snap), 128'(r));
    rst = 0;
    tick();

    vecs.push_back('{"illegal", 6'b010000, 1, 32'h88, 32'h200, 32'h100, 32'hFFFF, 0,
                     1, 32'd2, 32'h1880, 32'hFFFF, 32'h200, 4});
    vecs.push_back('{"ecall", 6'b001000, 1, 32'h1880, 32'h200, 32'h100, 32'hDEAD, 0,
                     1, 32'd11, 32'h1800, 0, 32'h200, 4});
    vecs.push_back('{"mret", 6'b000001, 1, 32'h1880, 32'h200, 32'h104, 0, 32'h104,
                     1, 0, 32'h1888, 0, 32'h104, 2});
    vecs.push_back('{"irq_vec", 6'b100000, 1, 32'h8, 32'h201, 32'h140, 32'h55, 0,
                     1, 32'h8000000B, 32'h1880, 0, 32'h22C, 4});
    vecs.push_back('{"irq_masked", 6'b100000, 1, 32'h0, 32'h201, 32'h140, 0, 0,
                     0, 0, 0, 0, 0, 0});
    vecs.push_back('{"irq_lf_mret", 6'b100101, 1, 32'h8, 32'h201, 32'h180, 32'h77, 32'h40,
                     1, 32'h8000000B, 32'h1880, 0, 32'h22C, 4});
    vecs.push_back('{"irq_nowb", 6'b100000, 0, 32'h8, 32'h200, 32'h1C0, 0, 0,
                     1, 32'h8000000B, 32'h1880, 0, 32'h200, 4});
    vecs.push_back('{"lf_nowb", 6'b000100, 0, 32'h8, 32'h200, 32'h1C0, 32'h9, 0,
                     0, 0, 0, 0, 0, 0});
    vecs.push_back('{"sf_mode11", 6'b000010, 1, 32'h88, 32'h203, 32'h200, 32'h1234, 0,
                     1, 32'd7, 32'h1880, 32'h1234, 32'h200, 4});
    vecs.push_back('{"lf_vec_exc", 6'b000100, 1, 32'h0, 32'h201, 32'h204, 32'hAB, 0,
                     1, 32'd5, 32'h1800, 32'hAB, 32'h200, 4});
    vecs.push_back('{"irq_mode10", 6'b100000, 1, 32'h8, 32'h202, 32'h208, 0, 0,
                     1, 32'h8000000B, 32'h1880, 0, 32'h200, 4});
    vecs.push_back('{"mret_mpie", 6'b000001, 1, 32'h80, 32'h200, 32'h20C, 0, 32'h3000,
                     1, 0, 32'h1888, 0, 32'h3000, 2});
    vecs.push_back('{"mret_mie", 6'b000001, 1, 32'h8, 32'h200, 32'h20C, 0, 32'h3004,
                     1, 0, 32'h1880, 0, 32'h3004, 2});
    vecs.push_back('{"ecall_mret", 6'b001001, 1, 32'h88, 32'h300, 32'h210, 32'h1, 32'h5,
                     1, 32'd11, 32'h1880, 0, 32'h300, 4});
    vecs.push_back('{"ecall_ones", 6'b001000, 1, 32'hFFFFFFFF, 32'h400, 32'h214, 0, 0,
                     1, 32'd11, 32'hFFFFFFF7, 0, 32'h400, 4});
    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while mcause is being written abandons the mstatus write.
    ex_ecall = 1; wb_valid = 1; mstatus = 32'h88; mtvec = 32'h200;
    wb_pc = 32'h500;
    tick();
    clr_ev();
    tick();
    rst = 1;
    tick();
    chk("rst_mid_waddr", 128'(snap.waddr), 128'(12'h342));
    rst = 0;
    tick();
    chk("rst_after_busy", 128'(snap.busy), 128'(0));
    chk("rst_after_w", 128'(snap.w), 128'(0));
    chk("rst_after_rv", 128'(snap.rv), 128'(0));
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (snap.w || snap.rv) seen++;
    end
    chk("rst_no_more_writes", 128'(seen), 128'(0));
    run_vec(vecs[1]);

    // Event held through REDIR is re-accepted on the following cycle.
    ex_ecall = 1; wb_valid = 1; mstatus = 32'h1800; mtvec = 32'h200;
    wb_pc = 32'h600;
    for (int k = 0; k < 5; k++) tick();
    chk("hold_redir", 128'(snap.rv), 128'(1));
    tick();
    chk("hold_reaccept_busy", 128'(snap.busy), 128'(1));
    chk("hold_reaccept_nowr", 128'(snap.w), 128'(0));
    tick();
    chk("hold_epc_waddr", 128'({snap.w, snap.waddr}), 128'({1'b1, 12'h341}));
    clr_ev();
    for (int k = 0; k < 4; k++) tick();

    // Random stimulus against the reference model.
    for (int n = 0; n < 600; n++) begin
      ex_illegal = ($urandom_range(0, 9) == 0);
      ex_ecall   = ($urandom_range(0, 9) == 0);
      ex_lfault  = ($urandom_range(0, 9) == 0);
      ex_sfault  = ($urandom_range(0, 9) == 0);
      irq_ext    = ($urandom_range(0, 7) == 0);
      wb_valid   = $urandom_range(0, 1);
      mret       = wb_valid && ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 4))
        0: mstatus = 32'h0;
        1: mstatus = 32'h8;
        2: mstatus = 32'h80;
        3: mstatus = 32'h88;
        default: mstatus = $urandom;
      endcase
      mtvec   = {$urandom_range(0, 255), $urandom_range(0, 3)} & 32'h3FF;
      mepc    = $urandom;
      wb_pc   = $urandom;
      wb_tval = $urandom;
      rst     = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 0;
    clr_ev();
    for (int k = 0; k < 6; k++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
